antilog: RTL and testbench

- Streaming inverse of the acoustic-front-end `log` block: converts a leading-ones-place code k back to a linear 32-bit magnitude.
- Used by the feature path and by verification to reconstruct approximate energies from log-domain features. It also feeds the reconstruction-error monitor.
- Two-stage registered pipeline with the same valid/last streaming convention as the front end, plus a per-frame sticky saturation flag.

---
 rtl/antilog.sv | 131 +++++++++++++
 tb/tb_antilog.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/antilog.sv
// Streaming antilog: maps a leading-ones-place code k back to a linear magnitude.
// Two registered stages (clamp, then shift) with a per-frame sticky saturation flag.
module antilog #(
  parameter int I_BW     = 8,
  parameter int O_BW     = 32,
  parameter int MIDPOINT = 0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic [O_BW-1:0] data_o,
  output logic            valid_o,
  output logic            last_o,
  output logic            sat_o
);

  localparam int KC_BW = $clog2(O_BW + 1);

  // Build the output magnitude for a clamped code (lower bound or bucket centre).
  function automatic logic [O_BW-1:0] decode_mag(input logic [KC_BW-1:0] kc);
    logic [O_BW-1:0] one;
    logic [O_BW-1:0] mag;
    one = O_BW'(1);
    mag = {O_BW{1'b0}};
    if (kc == KC_BW'(0)) begin
      mag = {O_BW{1'b0}};
    end else if (kc == KC_BW'(1)) begin
      mag = one;
    end else begin
      mag = one << (kc - KC_BW'(1));
      if (MIDPOINT != 32'sd0) begin
        mag = mag | (one << (kc - KC_BW'(2)));
      end else begin
        mag = mag;
      end
    end
    return mag;
  endfunction

  logic             accept_s;
  logic             over_s;
  logic [KC_BW-1:0] kc_r;
  logic             sat1_r;
  logic             valid1_r;
  logic             last1_r;

  logic             sticky_r;
  logic [O_BW-1:0]  data_r;
  logic             valid_r;
  logic             last_r;
  logic             sat_r;

  logic [O_BW-1:0]  data_nxt_s;
  logic             valid_nxt_s;
  logic             last_nxt_s;
  logic             sat_nxt_s;
  logic             sticky_nxt_s;

  assign accept_s = valid_i & en_i;
  // Codes are unsigned; anything above O_BW saturates to O_BW.
  assign over_s   = (32'(data_i) > 32'(O_BW));

  // Stage 1: clamp the code and capture the beat qualifiers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      kc_r     <= {KC_BW{1'b0}};
      sat1_r   <= 1'b0;
      valid1_r <= 1'b0;
      last1_r  <= 1'b0;
    end else begin
      valid1_r <= accept_s;
      last1_r  <= accept_s & last_i;
      if (accept_s) begin
        kc_r   <= over_s ? KC_BW'(O_BW) : data_i[KC_BW-1:0];
        sat1_r <= over_s;
      end else begin
        kc_r   <= kc_r;
        sat1_r <= 1'b0;
      end
    end
  end

  // Stage 2 next-state: shift decode and frame-sticky saturation.
  always_comb begin
    data_nxt_s   = data_r;
    valid_nxt_s  = 1'b0;
    last_nxt_s   = 1'b0;
    sat_nxt_s    = 1'b0;
    sticky_nxt_s = sticky_r;
    if (valid1_r) begin
      data_nxt_s  = decode_mag(kc_r);
      valid_nxt_s = 1'b1;
      last_nxt_s  = last1_r;
      sat_nxt_s   = sticky_r | sat1_r;
      if (last1_r) begin
        sticky_nxt_s = 1'b0;
      end else begin
        sticky_nxt_s = sticky_r | sat1_r;
      end
    end else begin
      data_nxt_s   = data_r;
      sticky_nxt_s = sticky_r;
    end
  end

  // Stage 2 registers; data holds across idle cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_r   <= {O_BW{1'b0}};
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      sat_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      data_r   <= data_nxt_s;
      valid_r  <= valid_nxt_s;
      last_r   <= last_nxt_s;
      sat_r    <= sat_nxt_s;
      sticky_r <= sticky_nxt_s;
    end
  end

  assign data_o  = data_r;
  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign sat_o   = sat_r;

endmodule

// File: tb/tb_antilog.sv
// Self-checking bench for antilog: both MIDPOINT settings driven in parallel,
// checked against a frame-level reference model with a 2-cycle delay line.
module tb_antilog;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;

  logic [31:0] data0, data1;
  logic        valid0, valid1, last0, last1, sat0, sat1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic        l;
    logic        s;
    int          kc;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t        pipe0, pipe1;
  logic        frame_sat;
  logic [31:0] held0, held1;

  always #5 clk_i = ~clk_i;

  antilog #(.I_BW(8), .O_BW(32), .MIDPOINT(0)) u_dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i),
    .data_o(data0), .valid_o(valid0), .last_o(last0), .sat_o(sat0));

  antilog #(.I_BW(8), .O_BW(32), .MIDPOINT(1)) u_dut1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i),
    .data_o(data1), .valid_o(valid1), .last_o(last1), .sat_o(sat1));

  // Reference magnitude: 2^(kc-1), plus 2^(kc-2) for the bucket centre.
  function automatic logic [31:0] ref_mag(input int k, input int mid);
    longint v;
    int kc;
    kc = (k > 32) ? 32 : k;
    if (kc == 0) v = 0;
    else if (kc == 1) v = 1;
    else begin
      v = longint'(1) << (kc - 1);
      if (mid != 0) v = v + (longint'(1) << (kc - 2));
    end
    return v[31:0];
  endfunction

  // Model of the front-end log block: 1-based place of the leading one.
  function automatic int log_of(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) if (x[i]) return i + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input exp_t e);
    if (e.v) begin
      held0 = e.d0;
      held1 = e.d1;
    end
    chk("valid0", 32'(valid0), 32'(e.v));
    chk("valid1", 32'(valid1), 32'(e.v));
    chk("data0", data0, held0);
    chk("data1", data1, held1);
    chk("last0", 32'(last0), 32'(e.v & e.l));
    chk("last1", 32'(last1), 32'(e.v & e.l));
    chk("sat0", 32'(sat0), 32'(e.v & e.s));
    chk("sat1", 32'(sat1), 32'(e.v & e.s));
    if (e.v) begin
      chk("roundtrip0", 32'(log_of(data0)), 32'(e.kc));
      chk("roundtrip1", 32'(log_of(data1)), 32'(e.kc));
    end
  endtask

  // One clock: drive inputs, model acceptance at the edge, check the 2-cycle-old beat.
  task automatic step(input logic v, input int k, input logic l, input logic e);
    valid_i = v;
    data_i  = 8'(k);
    last_i  = l;
    en_i    = e;
    @(posedge clk_i);
    pipe1 = pipe0;
    pipe0.v = v & e;
    pipe0.l = l;
    pipe0.s = 1'b0;
    pipe0.kc = (k > 32) ? 32 : k;
    pipe0.d0 = ref_mag(k, 0);
    pipe0.d1 = ref_mag(k, 1);
    if (v & e) begin
      frame_sat = frame_sat | (k > 32);
      pipe0.s = frame_sat;
      if (l) frame_sat = 1'b0;
    end
    @(negedge clk_i);
    check_out(pipe1);
  endtask

  task automatic clear_model();
    pipe0 = '{v: 1'b0, l: 1'b0, s: 1'b0, kc: 0, d0: 32'h0, d1: 32'h0};
    pipe1 = pipe0;
    frame_sat = 1'b0;
    held0 = 32'h0;
    held1 = 32'h0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data0"}, data0, 32'h0);
    chk({tag, "_data1"}, data1, 32'h0);
    chk({tag, "_ctl0"}, {29'h0, valid0, last0, sat0}, 32'h0);
    chk({tag, "_ctl1"}, {29'h0, valid1, last1, sat1}, 32'h0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    data_i  = 8'h0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    clear_model();
    #12;
    chk_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Basic codes, including the top code 32.
    step(1'b1, 0, 1'b0, 1'b1);
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b1, 32, 1'b1, 1'b1);
    step(1'b1, 3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);

    // Frame A with a saturating middle beat, then single-beat frame B.
    step(1'b1, 4, 1'b0, 1'b1);
    step(1'b1, 40, 1'b0, 1'b1);
    step(1'b1, 3, 1'b1, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // en_i low rejects 9 and 10; last_i without valid_i is ignored.
    step(1'b1, 8, 1'b0, 1'b1);
    step(1'b1, 9, 1'b1, 1'b0);
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b1, 11, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic with gaps, saturating codes and frame ends.
    for (int i = 0; i < 120; i++) begin
      int k;
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 255)) : int'($urandom_range(0, 32));
      step(1'(($urandom_range(0, 3) != 0)), k, 1'(($urandom_range(0, 4) == 0)),
           1'(($urandom_range(0, 5) != 0)));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);

    // Async reset with two beats in flight, one saturating.
    step(1'b1, 50, 1'b0, 1'b1);
    valid_i = 1'b1;
    data_i  = 8'd5;
    last_i  = 1'b0;
    @(posedge clk_i);
    valid_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("async_rst");
    clear_model();
    @(negedge clk_i);
    chk_zero("rst_hold");
    rst_n_i = 1'b1;
    step(1'b1, 6, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("post_rst_data0", held0, 32'h20);

    // Round-trip sweep 0..32 with random valid gaps.
    for (int k = 0; k <= 32; k++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, k, 1'(k == 32), 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
